fetch_unit: RTL

Instruction fetch stage of the 16-bit CPU. It holds the program counter, fetches one 16-bit instruction word per transaction from instruction memory over a req/ready handshake, and presents it to the control decoder. The decoder takes `opcode = instr[15:12]`. The block supports consumer back-pressure (`stall`) and branch redirection, including discarding a fetch already in flight.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings and
// the opcode field position within an instruction word.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2,
      S_HOLD    = 2'd3
   } fetch_state_e;

   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ready handshake,
// consumer back-pressure and branch redirection with in-flight discard.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [15:0] pc_out,
   output logic [15:0] pc_plus1
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  addr_q, addr_d;
   logic [15:0]  instr_q, instr_d;
   logic [15:0]  pc_out_q, pc_out_d;
   logic         vld_q, vld_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         instr_q  <= '0;
         pc_out_q <= RESET_PC;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         vld_q    <= vld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      vld_d    = vld_q;
      // Redirect always retargets pc; what happens to addr depends on
      // whether a transaction is still open on the bus.
      if (redirect_valid) pc_d = redirect_pc;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            addr_d  = redirect_valid ? redirect_pc : pc_q;
         end
         S_FETCH: begin
            if (redirect_valid) begin
               if (imem_ready) begin
                  addr_d  = redirect_pc;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DISCARD;
               end
            end else if (imem_ready) begin
               instr_d  = imem_rdata;
               pc_out_d = addr_q;
               pc_d     = pc_q + 16'd1;
               vld_d    = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_DISCARD: begin
            // Old address stays on the bus until memory completes it.
            if (!redirect_valid && imem_ready) begin
               addr_d  = pc_q;
               state_d = S_FETCH;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               vld_d   = 1'b0;
               addr_d  = redirect_pc;
               state_d = S_FETCH;
            end else if (!stall) begin
               vld_d   = 1'b0;
               addr_d  = pc_q;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = (state_q == S_FETCH) || (state_q == S_DISCARD);
   assign imem_addr   = addr_q;
   assign instr_valid = vld_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign pc_out      = pc_out_q;
   assign pc_plus1    = pc_out_q + 16'd1;

endmodule
